// File: rtl/run_tick_ctrl_if.sv
// Pushbutton/switch inputs and tick/clear/running outputs between the panel and run_tick_ctrl.
// master drives the keys and switch; slave is the control stage.
interface run_tick_ctrl_if;
  logic key_run_n;
  logic key_clear_n;
  logic sw_fast;
  logic tick;
  logic clear;
  logic running;

  modport master (
    output key_run_n,
    output key_clear_n,
    output sw_fast,
    input  tick,
    input  clear,
    input  running
  );

  modport slave (
    input  key_run_n,
    input  key_clear_n,
    input  sw_fast,
    output tick,
    output clear,
    output running
  );
endinterface

// File: rtl/run_tick_ctrl.sv
// RUN/CLEAR debounce, RUNNING/STOPPED control and tick prescaler for the hex counter.
// Pausing holds the prescaler so a resumed period keeps its phase.
module run_tick_ctrl #(
  parameter int unsigned TICK_DIV        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input logic        CLOCK_50,
  input logic        resetn,
  run_tick_ctrl_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] DIV_SLOW_M1 = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] DIV_FAST_M1 = PW'(TICK_DIV / 10 - 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_STOPPED, ST_RUNNING} state_t;

  // Key vectors: bit 0 = RUN, bit 1 = CLEAR.
  logic [1:0]    key_s1, key_s2, key_acc, key_armed, press_c, press_q;
  logic [DW-1:0] key_cnt [2];
  logic          fast_s1, fast_s2;
  logic [1:0]    vld;

  state_t        state;
  logic [PW-1:0] presc;
  logic [PW-1:0] div_m1;
  logic          tick_q, clear_q, running_q;
  logic          run_press, clr_press;

  // Two-flop synchronizers; vld marks when key_s2 holds a real pin sample after reset.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      key_s1  <= '1;
      key_s2  <= '1;
      fast_s1 <= 1'b0;
      fast_s2 <= 1'b0;
      vld     <= '0;
    end else begin
      key_s1  <= {bus.key_clear_n, bus.key_run_n};
      key_s2  <= key_s1;
      fast_s1 <= bus.sw_fast;
      fast_s2 <= fast_s1;
      vld     <= {vld[0], 1'b1};
    end
  end

  // A key only arms once it has been seen released, so a key held through reset stays silent.
  always_comb begin
    press_c = '0;
    for (int k = 0; k < 2; k++) begin
      press_c[k] = key_armed[k] & key_acc[k] & ~key_s2[k] & (key_cnt[k] == DB_LAST);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      key_acc   <= '1;
      key_armed <= '0;
      press_q   <= '0;
      for (int k = 0; k < 2; k++) key_cnt[k] <= '0;
    end else begin
      press_q <= press_c;
      for (int k = 0; k < 2; k++) begin
        key_armed[k] <= key_armed[k] | (vld[1] & key_s2[k]);
        if (key_s2[k] == key_acc[k]) begin
          key_cnt[k] <= '0;
        end else if (key_cnt[k] == DB_LAST) begin
          key_cnt[k] <= '0;
          key_acc[k] <= key_s2[k];
        end else begin
          key_cnt[k] <= key_cnt[k] + DW'(1);
        end
      end
    end
  end

  assign run_press = press_q[0];
  assign clr_press = press_q[1];
  assign div_m1    = fast_s2 ? DIV_FAST_M1 : DIV_SLOW_M1;

  // Run/stop state, prescaler and registered outputs; clear overrides a simultaneous run press.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_STOPPED;
      presc     <= '0;
      tick_q    <= 1'b0;
      clear_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      tick_q  <= 1'b0;
      clear_q <= 1'b0;
      if (clr_press) begin
        state     <= ST_STOPPED;
        presc     <= '0;
        clear_q   <= 1'b1;
        running_q <= 1'b0;
      end else begin
        // >= lets a switch to the short divisor fire once immediately when already past it.
        if (state == ST_RUNNING) begin
          if (presc >= div_m1) begin
            presc  <= '0;
            tick_q <= 1'b1;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        if (run_press) begin
          state     <= (state == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
          running_q <= (state != ST_RUNNING);
        end
      end
    end
  end

  assign bus.tick    = tick_q;
  assign bus.clear   = clear_q;
  assign bus.running = running_q;

endmodule

// File: tb/tb_run_tick_ctrl.sv
// Directed bench for run_tick_ctrl with TICK_DIV=20, DEBOUNCE_CYCLES=4.
// All sampling and driving happens 1 time unit after the rising edge.
module tb_run_tick_ctrl;
  logic CLOCK_50 = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;
  int   n;
  int   cnt;

  run_tick_ctrl_if bus();

  run_tick_ctrl #(
    .TICK_DIV        (20),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus.slave)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic step(input int k);
    repeat (k) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycles until tick is seen high, bounded at 100.
  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while (bus.tick !== 1'b1 && cycles < 100);
  endtask

  initial begin
    resetn          = 1'b0;
    bus.key_run_n   = 1'b1;
    bus.key_clear_n = 1'b1;
    bus.sw_fast     = 1'b0;
    step(2);
    chk("rst_tick", bus.tick, 0);
    chk("rst_clear", bus.clear, 0);
    chk("rst_running", bus.running, 0);
    resetn = 1'b1;
    step(3);

    // Clean run press: running rises on the 7th edge after the pin falls.
    bus.key_run_n = 1'b0;
    step(6);
    chk("run_early", bus.running, 0);
    step(1);
    chk("run_latency", bus.running, 1);
    step(3);
    bus.key_run_n = 1'b1;
    wait_tick(n);
    chk("first_tick", n, 17);
    step(1);
    chk("tick_width", bus.tick, 0);
    chk("clear_idle", bus.clear, 0);
    wait_tick(n);
    chk("tick_spacing", n, 19);

    // Stop so the prescaler holds 7, idle 50 cycles, resume.
    bus.key_run_n = 1'b0;
    step(7);
    chk("stopped", bus.running, 0);
    bus.key_run_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (bus.tick === 1'b1) cnt++;
    end
    chk("no_tick_stopped", cnt, 0);
    bus.key_run_n = 1'b0;
    step(7);
    chk("resumed", bus.running, 1);
    bus.key_run_n = 1'b1;
    wait_tick(n);
    chk("resume_phase", n, 13);

    // Fast switch at prescaler 15, then back to slow.
    step(15);
    bus.sw_fast = 1'b1;
    wait_tick(n);
    chk("fast_first", n, 3);
    wait_tick(n);
    chk("fast_spacing_a", n, 2);
    wait_tick(n);
    chk("fast_spacing_b", n, 2);
    bus.sw_fast = 1'b0;
    wait_tick(n);
    chk("slow_last_fast", n, 2);
    wait_tick(n);
    chk("slow_spacing", n, 20);

    // Run and clear accepted in the same cycle: clear wins.
    bus.key_run_n   = 1'b0;
    bus.key_clear_n = 1'b0;
    step(6);
    chk("clr_early", bus.clear, 0);
    step(1);
    chk("clr_pulse", bus.clear, 1);
    chk("clr_running", bus.running, 0);
    chk("clr_no_tick", bus.tick, 0);
    step(1);
    chk("clr_width", bus.clear, 0);
    bus.key_run_n   = 1'b1;
    bus.key_clear_n = 1'b1;
    step(10);

    // Run press with 3-cycle chatter before settling low.
    bus.key_run_n = 1'b0;
    step(3);
    bus.key_run_n = 1'b1;
    step(3);
    chk("chatter_a", bus.running, 0);
    bus.key_run_n = 1'b0;
    step(3);
    bus.key_run_n = 1'b1;
    step(3);
    chk("chatter_b", bus.running, 0);
    bus.key_run_n = 1'b0;
    step(6);
    chk("bounce_early", bus.running, 0);
    step(1);
    chk("bounce_run", bus.running, 1);
    wait_tick(n);
    chk("tick_after_clear", n, 20);
    chk("held_single", bus.running, 1);
    bus.key_run_n = 1'b1;

    // Reset mid-period with a key being pressed and held across release.
    step(5);
    bus.key_run_n = 1'b0;
    step(3);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_running", bus.running, 0);
    chk("async_rst_tick", bus.tick, 0);
    chk("async_rst_clear", bus.clear, 0);
    step(2);
    resetn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.running === 1'b1 || bus.clear === 1'b1 || bus.tick === 1'b1) cnt++;
    end
    chk("held_through_reset", cnt, 0);
    bus.key_run_n = 1'b1;
    step(10);
    bus.key_run_n = 1'b0;
    step(6);
    chk("repress_early", bus.running, 0);
    step(1);
    chk("repress_run", bus.running, 1);
    bus.key_run_n = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/run_tick_ctrl.md
# run_tick_ctrl

Upstream control stage for the on-board hex counter. It debounces the RUN and CLEAR pushbuttons and runs a RUNNING/STOPPED state machine. A prescaler generates the one-cycle `tick` enable that advances the downstream counter, plus a one-cycle `clear` pulse that zeroes it. `tick` replaces the free-running once-per-second compare: the counter advances only while running, and pausing preserves the phase of the current period.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per tick in normal mode (1 s at 50 MHz); must be ≥ 20 and divisible by 10.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles needed to accept a key level (20 ms); must be ≥ 2.
- `CLOCK_50`  in  1  system clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset; deassertion is synchronous to `CLOCK_50` externally.
- `key_run_n`  in  1  RUN/PAUSE pushbutton, active-low, asynchronous and bouncy.
- `key_clear_n`  in  1  CLEAR pushbutton, active-low, asynchronous and bouncy.
- `sw_fast`  in  1  slide switch, asynchronous; 1 selects a divisor of `TICK_DIV/10`.
- `tick`  out  1  registered one-cycle enable to the counter.
- `clear`  out  1  registered one-cycle synchronous clear to the counter.
- `running`  out  1  registered level; 1 while in RUNNING (drives an LED).

## Operation
- **Reset values (`resetn`=0):** `tick`=0, `clear`=0, `running`=0, state STOPPED, prescaler=0. Synchronizers and accepted key levels reset to 1 (released); debounce counters reset to 0. `sw_fast` synchronizer resets to 0.
- **Synchronizers:** each of the three async inputs passes through a 2-FF synchronizer before any use.
- **Debounce, per key:**
  - If the synchronized level equals the accepted level, the debounce counter resets to 0.
  - Otherwise it increments. When it reaches `DEBOUNCE_CYCLES-1`, the accepted level takes the new value and the counter resets.
  - A press event is a single-cycle pulse on the accepted level's 1→0 transition. Releases generate no event.
- **State machine, two states:**
  - STOPPED + run press → RUNNING.
  - RUNNING + run press → STOPPED.
  - Clear press in either state → STOPPED, prescaler := 0, `clear` pulsed.
  - Run and clear presses in the same cycle: clear wins; result is STOPPED with `clear` pulsed.
- **Divisor:** DIV = `TICK_DIV` if synchronized `sw_fast`=0, else `TICK_DIV/10`. Prescaler width is `$clog2(TICK_DIV)`.
- **Prescaler in RUNNING:**
  - If prescaler ≥ DIV-1, prescaler := 0 and `tick` is asserted next cycle.
  - Otherwise prescaler := prescaler+1.
  - The ≥ compare covers a `sw_fast` 0→1 switch while prescaler > `TICK_DIV/10`-1: exactly one tick fires on the next evaluation, then normal spacing resumes.
- **Prescaler in STOPPED:** holds its value (pause/resume preserves phase). It is zeroed only by clear or reset.
- **Pulse width:** `tick` and `clear` are never high for two consecutive cycles from a single event.
- **Output relations:** `tick` is never asserted in the same cycle as `clear`. `tick` is never asserted while `running`=0, except for the one cycle after a stop press that coincides with a wrap, where `tick` still fires once.

## Timing
- **Key latency:** edge at the pin → 2 synchronizer cycles → `DEBOUNCE_CYCLES` stable cycles → press event (cycle e).
  - `running` and `clear` update in cycle e+1.
  - Bounces shorter than `DEBOUNCE_CYCLES` are ignored.
- **First tick:** from a cleared prescaler, the first `tick` occurs DIV cycles after the first cycle `running`=1.
- **Tick spacing:** exactly DIV cycles between `tick` pulses while running.
- **Mid-operation reset:** asynchronous assertion forces all outputs low immediately. No pulse is emitted on reset release.
- **Held keys:** a key held continuously generates exactly one press event.

## Test plan
All scenarios use `TICK_DIV`=20 and `DEBOUNCE_CYCLES`=4.
- Reset, then a clean run press held 10 cycles → `running`=1 at sync+4+1 cycles. `tick` pulses every 20 cycles, each one cycle wide. `clear` stays 0.
- Run press with 3-cycle bounces (0/1/0/1) before settling low → exactly one press event and one STOPPED→RUNNING transition. Chatter shorter than 4 cycles produces no toggles.
- Run, stop at prescaler=7, wait 50 cycles, run again → no ticks while stopped. The first tick after resume comes 13 cycles after `running`=1.
- Run press and clear press reaching acceptance in the same cycle → `clear`=1 for one cycle, `running`=0, prescaler 0. The next run gives its first tick after 20 cycles.
- `sw_fast` toggled 0→1 while running with prescaler=15 → one tick about 3 cycles later (synchronizer plus compare), then ticks every 2 cycles. 1→0 → spacing returns to 20.
- `resetn` pulsed low while running, mid-period and during a key press → outputs 0 immediately, state STOPPED. A key still held at release produces no event until it is released and pressed again.
